// File: rtl/motor_spi_pkg.sv
// Shared definitions for the motor SPI transmit path: FSM states, frame
// geometry and the GoPiGo3 protocol constants.
package motor_spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } tx_state_e;

    // address + message id + port mask + 16-bit dps
    localparam int FRAME_W = 40;

    localparam logic [7:0] C_ADDR_DEF      = 8'h08;
    localparam logic [7:0] C_MSG_DPS_DEF   = 8'h0F;
    localparam logic [7:0] C_PORT_LEFT_DEF = 8'h01;
    localparam logic [7:0] C_PORT_RGHT_DEF = 8'h02;

    // Assemble one set-motor-dps frame, MSB is transmitted first.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [7:0]  addr,
        input logic [7:0]  msg,
        input logic [7:0]  port,
        input logic [15:0] dps
    );
        return {addr, msg, port, dps};
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Mode-0 SPI frame shifter: serialises one 40-bit frame with ss_n held low
// for 40 full SCK periods plus one trailing low half-period, then pulses done.
module spi_tx_shifter
    import motor_spi_pkg::*;
#(
    parameter int c_half_div = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               sclk_o,
    output logic               mosi_o,
    output logic               ss_n_o,
    output logic               done_o,
    output logic               shift_end_o,
    output logic               frame_end_o
);

    localparam int             DIV_W    = $clog2(c_half_div + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(c_half_div - 1);
    localparam logic [5:0]     BIT_LAST = 6'(FRAME_W - 1);

    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [5:0]         bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               ss_n_q, ss_n_d;
    logic               hold_q, hold_d;
    logic               active_q, active_d;
    logic               done_q, done_d;

    // Half-period sequencing: low phase (mosi updated), high phase, and a
    // final low hold before releasing ss_n.
    always_comb begin
        shreg_d  = shreg_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        ss_n_d   = ss_n_q;
        hold_d   = hold_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (!active_q) begin
            if (start_i) begin
                shreg_d  = {frame_i[FRAME_W-2:0], 1'b0};
                mosi_d   = frame_i[FRAME_W-1];
                ss_n_d   = 1'b0;
                sclk_d   = 1'b0;
                div_d    = '0;
                bit_d    = '0;
                hold_d   = 1'b0;
                active_d = 1'b1;
            end
        end else if (div_q != DIV_LAST) begin
            div_d = div_q + 1'b1;
        end else begin
            div_d = '0;
            if (hold_q) begin
                ss_n_d   = 1'b1;
                mosi_d   = 1'b0;
                active_d = 1'b0;
                hold_d   = 1'b0;
                done_d   = 1'b1;
            end else if (!sclk_q) begin
                sclk_d = 1'b1;
            end else begin
                sclk_d = 1'b0;
                if (bit_q == BIT_LAST) begin
                    hold_d = 1'b1;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    mosi_d  = shreg_q[FRAME_W-1];
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

    // State register; reset drops ss_n immediately and abandons the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ss_n_q   <= 1'b1;
            hold_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            ss_n_q   <= ss_n_d;
            hold_q   <= hold_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign mosi_o      = mosi_q;
    assign ss_n_o      = ss_n_q;
    assign done_o      = done_q;
    assign shift_end_o = active_q & ~hold_q & sclk_q & (div_q == DIV_LAST) & (bit_q == BIT_LAST);
    assign frame_end_o = active_q & hold_q & (div_q == DIV_LAST);

endmodule

// File: rtl/motor_dps_spi_tx.sv
// Sends left/right wheel dps commands to the GoPiGo3 over write-only SPI.
// A transaction (left frame, gap, right frame, gap) starts on a command
// change or when the keep-alive timer expires.
module motor_dps_spi_tx
    import motor_spi_pkg::*;
#(
    parameter int          nb_dps_motor = 16,
    parameter int          c_half_div   = 100,
    parameter int          c_gap        = 100,
    parameter int          nb_refresh   = 24,
    parameter int          c_refresh    = 5000000,
    parameter logic [7:0]  c_addr       = C_ADDR_DEF,
    parameter logic [7:0]  c_msg_dps    = C_MSG_DPS_DEF,
    parameter logic [7:0]  c_port_left  = C_PORT_LEFT_DEF,
    parameter logic [7:0]  c_port_rght  = C_PORT_RGHT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic signed [nb_dps_motor-1:0] motor_dps_left_i,
    input  logic signed [nb_dps_motor-1:0] motor_dps_rght_i,
    output logic                           sclk_o,
    output logic                           mosi_o,
    output logic                           ss_n_o,
    output logic                           busy_o,
    output logic                           frame_done_o
);

    localparam int                GAP_W    = $clog2(c_gap + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(c_gap - 1);
    localparam logic [nb_refresh-1:0] REF_LAST = nb_refresh'(c_refresh - 1);

    tx_state_e                     state_q, state_d;
    logic signed [nb_dps_motor-1:0] last_left_q, last_left_d;
    logic signed [nb_dps_motor-1:0] last_rght_q, last_rght_d;
    logic [nb_refresh-1:0]         refresh_q, refresh_d;
    logic [GAP_W-1:0]              gap_q, gap_d;
    logic                          second_q, second_d;
    logic                          busy_q;

    logic                          tx_due;
    logic                          start;
    logic [FRAME_W-1:0]            frame;
    logic                          shift_end;
    logic                          frame_end;

    // Frame sequencing, change/keep-alive detection and snapshot capture.
    always_comb begin
        state_d     = state_q;
        last_left_d = last_left_q;
        last_rght_d = last_rght_q;
        refresh_d   = refresh_q;
        gap_d       = gap_q;
        second_d    = second_q;
        start       = 1'b0;
        frame       = '0;
        tx_due      = enable && ((motor_dps_left_i != last_left_q) ||
                                 (motor_dps_rght_i != last_rght_q) ||
                                 (refresh_q == REF_LAST));
        case (state_q)
            S_IDLE: begin
                if (refresh_q != REF_LAST) refresh_d = refresh_q + 1'b1;
                if (tx_due) state_d = S_LOAD;
            end
            S_LOAD: begin
                refresh_d   = '0;
                last_left_d = motor_dps_left_i;
                last_rght_d = motor_dps_rght_i;
                second_d    = 1'b0;
                start       = 1'b1;
                frame       = build_frame(c_addr, c_msg_dps, c_port_left, motor_dps_left_i);
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                if (shift_end) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (frame_end) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (!second_q) begin
                        start    = 1'b1;
                        frame    = build_frame(c_addr, c_msg_dps, c_port_rght, last_rght_q);
                        second_d = 1'b1;
                        state_d  = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state; busy is registered from the next state so it is high
    // during LOAD and low from the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_left_q <= '0;
            last_rght_q <= '0;
            refresh_q   <= '0;
            gap_q       <= '0;
            second_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_left_q <= last_left_d;
            last_rght_q <= last_rght_d;
            refresh_q   <= refresh_d;
            gap_q       <= gap_d;
            second_q    <= second_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    spi_tx_shifter #(
        .c_half_div (c_half_div)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .frame_i     (frame),
        .sclk_o      (sclk_o),
        .mosi_o      (mosi_o),
        .ss_n_o      (ss_n_o),
        .done_o      (frame_done_o),
        .shift_end_o (shift_end),
        .frame_end_o (frame_end)
    );

    assign busy_o = busy_q;

endmodule

// File: tb/tb_motor_dps_spi_tx.sv
// Self-checking bench for motor_dps_spi_tx: an SPI monitor decodes frames
// from the pins; a vector table plus directed sequences check the traffic.
module tb_motor_dps_spi_tx;

    localparam int H   = 2;
    localparam int GAP = 4;
    localparam int REF = 1000;
    localparam int LOW_CYC = 81 * H;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic signed [15:0] left = '0;
    logic signed [15:0] rght = '0;
    logic               sclk_o, mosi_o, ss_n_o, busy_o, frame_done_o;

    always #5 clk = ~clk;

    motor_dps_spi_tx #(
        .nb_dps_motor (16),
        .c_half_div   (H),
        .c_gap        (GAP),
        .nb_refresh   (24),
        .c_refresh    (REF)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .motor_dps_left_i (left),
        .motor_dps_rght_i (rght),
        .sclk_o           (sclk_o),
        .mosi_o           (mosi_o),
        .ss_n_o           (ss_n_o),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o)
    );

    typedef struct {
        logic [39:0] bits;
        int          nbits;
        int          low;
    } frame_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        en;
        logic        exp_tx;
        logic [39:0] el;
        logic [39:0] er;
    } vec_t;

    frame_t frames[$];
    int checks = 0;
    int errors = 0;
    int sck_rises = 0;
    int done_pulses = 0;
    int mode_viol = 0;

    // Pin monitor, sampled on the falling edge.
    initial begin
        logic        prev_sclk, prev_ss_n, prev_mosi, prev_rst, cap_valid;
        logic [39:0] cap_bits;
        int          cap_n, cap_low, mosi_age;
        prev_sclk = 0; prev_ss_n = 1; prev_mosi = 0; prev_rst = 1; cap_valid = 0;
        cap_bits = '0; cap_n = 0; cap_low = 0; mosi_age = 0;
        forever begin
            @(negedge clk);
            if (frame_done_o) done_pulses++;
            if (!rst && !prev_rst && (ss_n_o != prev_ss_n) && (sclk_o || prev_sclk)) mode_viol++;
            if (mosi_o != prev_mosi) begin
                if (sclk_o) mode_viol++;
                mosi_age = 1;
            end else begin
                mosi_age++;
            end
            if (!ss_n_o && prev_ss_n) begin
                cap_valid = 1; cap_bits = '0; cap_n = 0; cap_low = 0;
            end
            if (sclk_o && !prev_sclk) begin
                sck_rises++;
                if (mosi_age <= H) mode_viol++;
                cap_bits = {cap_bits[38:0], mosi_o};
                cap_n++;
            end
            if (!ss_n_o) cap_low++;
            if (rst) cap_valid = 0;
            if (ss_n_o && !prev_ss_n && cap_valid) begin
                frames.push_back('{cap_bits, cap_n, cap_low});
                cap_valid = 0;
            end
            prev_sclk = sclk_o; prev_ss_n = ss_n_o; prev_mosi = mosi_o; prev_rst = rst;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] l, input logic [15:0] r, input logic en);
        @(posedge clk);
        #1;
        left = l; rght = r; enable = en;
    endtask

    task automatic wait_busy(input logic val, input int bound, output logic got);
        got = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (busy_o === val) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic wait_ssn_low(input int bound, output logic got);
        got = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (ss_n_o === 1'b0) begin
                got = 1;
                break;
            end
        end
    endtask

    // Pops one transaction (two frames) from the monitor and compares it.
    task automatic check_tx(input string tag, input logic [39:0] el, input logic [39:0] er);
        frame_t f;
        logic [39:0] ef;
        if (frames.size() < 2) begin
            checks++;
            errors++;
            $display("FAIL %s_frames: got %0d frames expected 2", tag, frames.size());
            frames.delete();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            f  = frames.pop_front();
            ef = (i == 0) ? el : er;
            chk($sformatf("%s_f%0d_bits", tag, i), 64'(f.bits), 64'(ef));
            chk($sformatf("%s_f%0d_nbits", tag, i), 64'(f.nbits), 64'd40);
            chk($sformatf("%s_f%0d_ssn_low", tag, i), 64'(f.low), 64'(LOW_CYC));
        end
        $display("tx %s: left=%010h right=%010h", tag, el, er);
    endtask

    initial begin
        vec_t vecs[8];
        logic got;
        int   n, d0, s0;

        vecs[0] = '{16'd600,  16'hFF06, 1'b1, 1'b1, 40'h080F010258, 40'h080F02FF06};
        vecs[1] = '{16'd600,  16'hFF06, 1'b1, 1'b0, 40'h0,          40'h0};
        vecs[2] = '{16'd150,  16'hFF06, 1'b1, 1'b1, 40'h080F010096, 40'h080F02FF06};
        vecs[3] = '{16'd150,  16'h7FFF, 1'b1, 1'b1, 40'h080F010096, 40'h080F027FFF};
        vecs[4] = '{16'h8000, 16'hFFFF, 1'b1, 1'b1, 40'h080F018000, 40'h080F02FFFF};
        vecs[5] = '{16'd1,    16'd2,    1'b0, 1'b0, 40'h0,          40'h0};
        vecs[6] = '{16'd1,    16'd2,    1'b1, 1'b1, 40'h080F010001, 40'h080F020002};
        vecs[7] = '{16'd0,    16'd0,    1'b1, 1'b1, 40'h080F010000, 40'h080F020000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ss_n", 64'(ss_n_o), 64'd1);
        chk("rst_sclk", 64'(sclk_o), 64'd0);
        chk("rst_mosi", 64'(mosi_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(frame_done_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            d0 = done_pulses;
            drive(vecs[i].l, vecs[i].r, vecs[i].en);
            wait_busy(1'b1, 20, got);
            chk($sformatf("v%0d_started", i), 64'(got), 64'(vecs[i].exp_tx));
            if (got) begin
                wait_busy(1'b0, 800, got);
                chk($sformatf("v%0d_finished", i), 64'(got), 64'd1);
                check_tx($sformatf("v%0d", i), vecs[i].el, vecs[i].er);
                chk($sformatf("v%0d_done_pulses", i), 64'(done_pulses - d0), 64'd2);
            end else begin
                chk($sformatf("v%0d_no_frames", i), 64'(frames.size()), 64'd0);
            end
        end

        // Keep-alive: exactly REF idle cycles, then identical bytes
        n = 1;
        for (int k = 0; k < REF + 100; k++) begin
            @(negedge clk);
            if (busy_o) break;
            n++;
        end
        chk("refresh_idle_cycles", 64'(n), 64'(REF));
        chk("refresh_no_early_traffic", 64'(frames.size()), 64'd0);
        wait_busy(1'b0, 800, got);
        chk("refresh_finished", 64'(got), 64'd1);
        check_tx("refresh", 40'h080F010000, 40'h080F020000);

        // Change during the right frame: old snapshot, then immediate follow-up
        drive(16'd300, 16'd5, 1'b1);
        wait_busy(1'b1, 20, got);
        chk("chg_started", 64'(got), 64'd1);
        got = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (frames.size() == 1 && ss_n_o === 1'b0) begin
                got = 1;
                break;
            end
        end
        chk("chg_right_frame_seen", 64'(got), 64'd1);
        drive(16'd150, 16'd5, 1'b1);
        wait_busy(1'b0, 800, got);
        chk("chg_first_finished", 64'(got), 64'd1);
        n = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy_o) break;
            n++;
        end
        chk("chg_idle_between", 64'(n), 64'd1);
        wait_busy(1'b0, 800, got);
        chk("chg_second_finished", 64'(got), 64'd1);
        chk("chg_frame_count", 64'(frames.size()), 64'd4);
        check_tx("chg_old", 40'h080F01012C, 40'h080F020005);
        check_tx("chg_new", 40'h080F010096, 40'h080F020005);

        // enable dropped mid-left-frame: both frames still complete
        drive(16'hFFF9, 16'd9, 1'b1);
        wait_busy(1'b1, 20, got);
        chk("en_started", 64'(got), 64'd1);
        s0 = sck_rises;
        wait_ssn_low(20, got);
        chk("en_ssn_low", 64'(got), 64'd1);
        repeat (20) @(negedge clk);
        drive(16'd77, 16'd9, 1'b0);
        wait_busy(1'b0, 800, got);
        chk("en_finished", 64'(got), 64'd1);
        chk("en_sck_rises", 64'(sck_rises - s0), 64'd80);
        check_tx("en_drop", 40'h080F01FFF9, 40'h080F020009);
        wait_busy(1'b1, 50, got);
        chk("en_stays_idle", 64'(got), 64'd0);
        chk("en_no_frames", 64'(frames.size()), 64'd0);

        // Reset mid-frame, then full restart because last_sent was cleared
        d0 = done_pulses;
        drive(16'd77, 16'd9, 1'b1);
        wait_ssn_low(20, got);
        chk("rmid_ssn_low", 64'(got), 64'd1);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rmid_ss_n", 64'(ss_n_o), 64'd1);
        chk("rmid_sclk", 64'(sclk_o), 64'd0);
        chk("rmid_busy", 64'(busy_o), 64'd0);
        chk("rmid_no_pulse", 64'(done_pulses - d0), 64'd0);
        wait_busy(1'b1, 20, got);
        chk("rmid_restarted", 64'(got), 64'd1);
        wait_busy(1'b0, 800, got);
        chk("rmid_finished", 64'(got), 64'd1);
        chk("rmid_frame_count", 64'(frames.size()), 64'd2);
        check_tx("rmid", 40'h080F01004D, 40'h080F020009);
        chk("rmid_done_pulses", 64'(done_pulses - d0), 64'd2);

        // Input changes and returns to the snapshot before IDLE: no follow-up
        drive(16'd78, 16'd9, 1'b1);
        wait_busy(1'b1, 20, got);
        chk("back_started", 64'(got), 64'd1);
        repeat (50) @(negedge clk);
        drive(16'd99, 16'd9, 1'b1);
        repeat (50) @(negedge clk);
        drive(16'd78, 16'd9, 1'b1);
        wait_busy(1'b0, 800, got);
        chk("back_finished", 64'(got), 64'd1);
        check_tx("back", 40'h080F01004E, 40'h080F020009);
        wait_busy(1'b1, 40, got);
        chk("back_no_retx", 64'(got), 64'd0);

        // SPI mode-0 timing over the whole run
        chk("spi_mode_violations", 64'(mode_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
